// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, data first,
// one transaction at a time, with a bounded wait that aborts a stuck memory.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    // Requester handshake: req is raised and held until the one-cycle ack.
    // req is only sampled in IDLE, so dropping it after the grant does not
    // cancel the transaction; it still completes and the ack still pulses.
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_enable,
    output logic              mem_rw,
    output logic [1:0]        mem_access_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy,

    output logic              grant_d,
    output logic              timeout_err,
    output logic [1:0]        state_o
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                grant_d_q, grant_d_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                rw_q,      rw_d;
    logic [1:0]          size_q,    size_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                terr_q,    terr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_d_q <= 1'b0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            size_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_d_q <= grant_d_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d_d = grant_d_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        terr_d    = terr_q;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    grant_d_d = 1'b1;
                    addr_d    = d_addr;
                    rw_d      = d_rw;
                    size_d    = (d_size == 2'b11) ? SIZE_WORD : d_size;
                    wdata_d   = d_wdata;
                    state_d   = ISSUE;
                end else if (i_req) begin
                    grant_d_d = 1'b0;
                    addr_d    = i_addr;
                    rw_d      = 1'b0;
                    size_d    = SIZE_WORD;
                    wdata_d   = '0;
                    state_d   = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                if (!mem_busy) begin
                    // A write ack always returns zero data to the data port.
                    if (grant_d_q) begin
                        d_rdata_d = rw_q ? '0 : mem_dout;
                    end else begin
                        i_rdata_d = mem_dout;
                    end
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    terr_d = 1'b1;
                    if (grant_d_q) begin
                        d_rdata_d = '0;
                    end else begin
                        i_rdata_d = '0;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_enable      = (state_q == ISSUE);
    assign i_ack           = (state_q == RESP) && !grant_d_q;
    assign d_ack           = (state_q == RESP) &&  grant_d_q;
    assign i_rdata         = i_rdata_q;
    assign d_rdata         = d_rdata_q;
    assign mem_rw          = rw_q;
    assign mem_access_size = size_q;
    assign mem_addr        = addr_q;
    assign mem_din         = wdata_q;
    assign grant_d         = grant_d_q;
    assign timeout_err     = terr_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model with a per-cycle
// compare, an ack scoreboard, directed scenarios and randomized traffic.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_rw;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_busy;
  wire               i_ack;
  wire  [DATA_W-1:0] i_rdata;
  wire               d_ack;
  wire  [DATA_W-1:0] d_rdata;
  wire               mem_enable;
  wire               mem_rw;
  wire  [1:0]        mem_access_size;
  wire  [ADDR_W-1:0] mem_addr;
  wire  [DATA_W-1:0] mem_din;
  wire               grant_d;
  wire               timeout_err;
  wire  [1:0]        state_dbg;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_ack          (i_ack),
    .i_rdata        (i_rdata),
    .d_req          (d_req),
    .d_rw           (d_rw),
    .d_size         (d_size),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_ack          (d_ack),
    .d_rdata        (d_rdata),
    .mem_enable     (mem_enable),
    .mem_rw         (mem_rw),
    .mem_access_size(mem_access_size),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_busy       (mem_busy),
    .grant_d        (grant_d),
    .timeout_err    (timeout_err),
    .state_o        (state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: one outstanding transaction, described by its grant,
  // issue and ack cycle numbers
  bit                model_ready = 0;
  bit                t_valid = 0;
  bit                t_is_d, t_rw, t_to;
  int                t_issue, t_ack;
  logic [DATA_W-1:0] t_data;

  logic              e_enable, e_iack, e_dack, e_grant_d, e_rw, e_terr;
  logic [1:0]        e_size;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_din, e_irdata, e_drdata;

  logic [DATA_W:0]   exp_q[$];

  // memory responder
  int                m_issue = -1000;
  int                m_L = 0;
  logic [DATA_W-1:0] m_D = '0;
  int                force_L = -1;
  bit                force_D_en = 0;
  logic [DATA_W-1:0] force_D = '0;

  // observations of the DUT for directed literal checks
  int                n_en, n_iack, n_dack, last_iack_cyc, last_dack_cyc;
  logic [DATA_W-1:0] last_irdata, last_drdata;
  logic              en_grant[8];
  logic              en_rw[8];
  logic [1:0]        en_size[8];
  logic [DATA_W-1:0] en_din[8];

  // random requester knobs
  bit rand_mode = 0;
  int p_raise_d = 30, p_raise_i = 30, p_b2b_d = 30, p_b2b_i = 30;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    n_en = 0; n_iack = 0; n_dack = 0;
    last_iack_cyc = -1; last_dack_cyc = -1;
    last_irdata = '0; last_drdata = '0;
  endtask

  // advance the model across the clock edge that ends cycle cyc
  task automatic model_step();
    if (rst) begin
      t_valid = 0;
      e_enable = 0; e_iack = 0; e_dack = 0; e_grant_d = 0; e_rw = 0; e_terr = 0;
      e_size = '0; e_addr = '0; e_din = '0; e_irdata = '0; e_drdata = '0;
      model_ready = 1;
    end else begin
      e_enable = 0; e_iack = 0; e_dack = 0;
      if (!t_valid) begin
        if (d_req) begin
          t_valid = 1; t_is_d = 1; t_rw = d_rw;
          e_addr = d_addr; e_rw = d_rw; e_din = d_wdata;
          e_size = (d_size == 2'b11) ? 2'b10 : d_size;
        end else if (i_req) begin
          t_valid = 1; t_is_d = 0; t_rw = 0;
          e_addr = i_addr; e_rw = 0; e_din = '0; e_size = 2'b10;
        end
        if (t_valid) begin
          t_issue = cyc + 1;
          t_ack = -1;
          e_enable = 1;
          e_grant_d = t_is_d;
        end
      end else begin
        if (cyc + 1 == t_ack) begin
          if (t_is_d) begin e_dack = 1; e_drdata = t_data; end
          else        begin e_iack = 1; e_irdata = t_data; end
          if (t_to) e_terr = 1;
          exp_q.push_back({t_is_d, t_data});
        end
        if (cyc == t_ack) t_valid = 0;
      end
    end
  endtask

  task automatic compare();
    logic [DATA_W:0] front;
    if (!model_ready) return;
    check("mem_enable", 64'(mem_enable), 64'(e_enable));
    check("i_ack", 64'(i_ack), 64'(e_iack));
    check("d_ack", 64'(d_ack), 64'(e_dack));
    check("i_rdata", 64'(i_rdata), 64'(e_irdata));
    check("d_rdata", 64'(d_rdata), 64'(e_drdata));
    check("mem_rw", 64'(mem_rw), 64'(e_rw));
    check("mem_access_size", 64'(mem_access_size), 64'(e_size));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_din", 64'(mem_din), 64'(e_din));
    check("grant_d", 64'(grant_d), 64'(e_grant_d));
    check("timeout_err", 64'(timeout_err), 64'(e_terr));
    if (i_ack || d_ack) begin
      check("ack_exclusive", 64'(i_ack && d_ack), 64'(0));
      check("ack_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        front = exp_q.pop_front();
        check("ack_scoreboard", 64'({d_ack, d_ack ? d_rdata : i_rdata}), 64'(front));
      end
    end
    if (mem_enable) begin
      if (n_en < 8) begin
        en_grant[n_en] = grant_d; en_rw[n_en] = mem_rw;
        en_size[n_en] = mem_access_size; en_din[n_en] = mem_din;
      end
      n_en++;
    end
    if (i_ack) begin n_iack++; last_iack_cyc = cyc; last_irdata = i_rdata; end
    if (d_ack) begin n_dack++; last_dack_cyc = cyc; last_drdata = d_rdata; end
  endtask

  task automatic new_d();
    d_req = 1; d_rw = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 3));
    d_addr = $urandom; d_wdata = $urandom;
  endtask

  task automatic new_i();
    i_req = 1; i_addr = $urandom;
  endtask

  task automatic drive_random();
    if (d_req && e_dack) begin
      d_req = 0;
      if ($urandom_range(0, 99) < p_b2b_d) new_d();
    end else if (!d_req) begin
      if ($urandom_range(0, 99) < p_raise_d) new_d();
    end else if ($urandom_range(0, 299) == 0) begin
      d_req = 0;
    end
    if (i_req && e_iack) begin
      i_req = 0;
      if ($urandom_range(0, 99) < p_b2b_i) new_i();
    end else if (!i_req) begin
      if ($urandom_range(0, 99) < p_raise_i) new_i();
    end else if ($urandom_range(0, 299) == 0) begin
      i_req = 0;
    end
  endtask

  // memory answers after L busy cycles; a stuck memory (L >= TIMEOUT) is aborted
  task automatic memory_drive();
    int r, w;
    if (t_valid && cyc == t_issue) begin
      r = int'($urandom_range(0, 15));
      m_issue = cyc;
      m_L = (force_L >= 0) ? force_L : ((r < 13) ? (r % 4) : (TIMEOUT + r - 13));
      m_D = force_D_en ? force_D : $urandom;
      t_to = (m_L >= TIMEOUT);
      w = t_to ? TIMEOUT : m_L + 1;
      t_ack = t_issue + w + 1;
      t_data = (t_rw || t_to) ? '0 : m_D;
    end
    mem_busy = (cyc > m_issue) && (cyc <= m_issue + m_L);
    mem_dout = (cyc == m_issue + m_L + 1) ? m_D : $urandom;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    compare();
    if (rand_mode) drive_random();
    memory_drive();
  endtask

  task automatic wait_done(input int max_cycles);
    bit done;
    done = 0;
    for (int k = 0; k < max_cycles && !done; k++) begin
      tick();
      if (e_iack) i_req = 0;
      if (e_dack) d_req = 0;
      done = !t_valid && !i_req && !d_req;
    end
    check("directed_done", 64'(done), 64'(1));
  endtask

  initial begin
    int c0;
    rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_rw = 0; d_size = '0;
    d_addr = '0; d_wdata = '0; mem_dout = '0; mem_busy = 0;
    clear_obs();
    repeat (3) tick();
    check("reset_state", 64'(state_dbg), 64'(0));
    check("reset_timeout_err", 64'(timeout_err), 64'(0));
    rst = 0;
    tick();

    // single fetch, memory busy for 2 cycles
    clear_obs(); c0 = cyc;
    force_L = 2; force_D_en = 1; force_D = 32'h8C010004;
    i_req = 1; i_addr = 32'h0000_0040;
    wait_done(30);
    check("fetch_enable_count", 64'(n_en), 64'(1));
    check("fetch_ack_count", 64'(n_iack), 64'(1));
    check("fetch_ack_latency", 64'(last_iack_cyc - c0), 64'(5));
    check("fetch_rdata", 64'(last_irdata), 64'(32'h8C010004));
    check("fetch_rw", 64'(en_rw[0]), 64'(0));
    check("fetch_size", 64'(en_size[0]), 64'(2));

    // simultaneous requests: data write first, then fetch
    tick(); clear_obs(); c0 = cyc;
    force_L = 1; force_D = 32'h1111_2222;
    d_req = 1; d_rw = 1; d_size = 2'b00; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    i_req = 1; i_addr = 32'h200;
    wait_done(40);
    check("both_enable_count", 64'(n_en), 64'(2));
    check("both_first_grant", 64'(en_grant[0]), 64'(1));
    check("both_first_din", 64'(en_din[0]), 64'(32'hDEADBEEF));
    check("both_first_size", 64'(en_size[0]), 64'(0));
    check("both_second_grant", 64'(en_grant[1]), 64'(0));
    check("both_second_din", 64'(en_din[1]), 64'(0));
    check("both_dack_latency", 64'(last_dack_cyc - c0), 64'(4));
    check("both_write_rdata", 64'(last_drdata), 64'(0));
    check("both_iack_latency", 64'(last_iack_cyc - c0), 64'(9));
    check("both_fetch_rdata", 64'(last_irdata), 64'(32'h1111_2222));

    // memory ready on the first wait cycle
    tick(); clear_obs(); c0 = cyc;
    force_L = 0; force_D = 32'hA5A5_0F0F;
    d_req = 1; d_rw = 0; d_size = 2'b11; d_addr = 32'h44;
    wait_done(20);
    check("fast_dack_latency", 64'(last_dack_cyc - c0), 64'(3));
    check("fast_read_rdata", 64'(last_drdata), 64'(32'hA5A5_0F0F));

    // stuck memory aborts after TIMEOUT wait cycles, flag is sticky
    tick(); clear_obs(); c0 = cyc;
    force_L = 20; force_D = 32'hFFFF_FFFF;
    d_req = 1; d_rw = 0; d_size = 2'b10; d_addr = 32'h80;
    wait_done(30);
    check("timeout_dack_latency", 64'(last_dack_cyc - c0), 64'(6));
    check("timeout_rdata", 64'(last_drdata), 64'(0));
    check("timeout_flag", 64'(timeout_err), 64'(1));
    tick(); clear_obs(); c0 = cyc;
    force_L = 0; force_D = 32'h1234_5678;
    i_req = 1; i_addr = 32'h300;
    wait_done(20);
    check("after_timeout_latency", 64'(last_iack_cyc - c0), 64'(3));
    check("after_timeout_rdata", 64'(last_irdata), 64'(32'h1234_5678));
    check("timeout_flag_sticky", 64'(timeout_err), 64'(1));

    // reset while waiting on memory: no ack, late completion ignored
    tick(); clear_obs(); c0 = cyc;
    force_L = 10; force_D = 32'h5555_AAAA;
    d_req = 1; d_rw = 0; d_addr = 32'hC0;
    tick(); tick(); tick();
    rst = 1; d_req = 0;
    tick();
    rst = 0;
    check("reset_mid_state", 64'(state_dbg), 64'(0));
    check("reset_mid_addr", 64'(mem_addr), 64'(0));
    check("reset_mid_timeout_err", 64'(timeout_err), 64'(0));
    repeat (15) tick();
    check("reset_mid_no_ack", 64'(n_dack + n_iack), 64'(0));
    check("reset_mid_one_enable", 64'(n_en), 64'(1));

    // randomized traffic with occasional resets
    force_L = -1; force_D_en = 0; rand_mode = 1;
    for (int k = 0; k < 2500; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    // data port held busy back to back; fetch only gets the gaps
    p_raise_d = 90; p_b2b_d = 85; p_raise_i = 60; p_b2b_i = 50;
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    rand_mode = 0; rst = 0; i_req = 0; d_req = 0;
    repeat (40) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
